// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared CDB constants, source IDs and round-robin helpers
//
// Purpose: common definitions for the CDB arbiter and its source FIFOs.
//   ROBENTRY_W    : default ROB tag width
//   ENTRY_NULL    : tag value meaning "no ROB entry"
//   cdb_src_e     : CDB source identifiers (ALU, LOAD, STORE)
//   cdb_src_next  : successor in the ALU->LOAD->STORE->ALU ring
//   cdb_rr_pick   : first requesting source scanning from a start point
package cdb_arbiter_pkg;

  localparam int ROBENTRY_W = 6;
  localparam int ENTRY_NULL = 0;
  localparam int NUM_SRC    = 3;

  typedef enum logic [1:0] {
    CDB_SRC_ALU   = 2'd0,
    CDB_SRC_LOAD  = 2'd1,
    CDB_SRC_STORE = 2'd2
  } cdb_src_e;

  typedef struct packed {
    logic     hit;
    cdb_src_e id;
  } cdb_grant_t;

  function automatic cdb_src_e cdb_src_next(input cdb_src_e s);
    case (s)
      CDB_SRC_ALU:  return CDB_SRC_LOAD;
      CDB_SRC_LOAD: return CDB_SRC_STORE;
      default:      return CDB_SRC_ALU;
    endcase
  endfunction

  // req is indexed by source ID; bit 3 is never requested and keeps the
  // index range covering every 2-bit value.
  function automatic cdb_grant_t cdb_rr_pick(input cdb_src_e start, input logic [3:0] req);
    cdb_grant_t g;
    cdb_src_e   idx;
    g.hit = 1'b0;
    g.id  = CDB_SRC_ALU;
    idx   = start;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (!g.hit && req[idx]) begin
        g.hit = 1'b1;
        g.id  = idx;
      end
      idx = cdb_src_next(idx);
    end
    return g;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// rtl/cdb_src_fifo.sv - per-source completion FIFO feeding the CDB arbiter
//
// Purpose: small synchronous FIFO holding completed results of one source.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   flush        : empties the FIFO (mispredict rollback)
//   push, din    : append din when not full
//   pop          : drop the head entry when not empty
//   head         : current head entry (valid while count != 0)
//   count        : number of stored entries, 0..DEPTH
//   full         : registered count == DEPTH
module cdb_src_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int               PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
  endfunction

  // A push while full is a protocol violation and is dropped here.
  assign push_ok = push && !full_q;
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop_ok)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d = (count_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage needs no reset: entries are only read while count != 0.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = full_q;

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter sharing one registered CDB among ALU/LOAD/STORE
//
// Purpose: buffers completions of three sources in per-source FIFOs and
// broadcasts at most one result per cycle on a registered common data bus.
// Ports:
//   clk, rst, rdy, rollback          : clock, sync reset, global enable, flush
//   alu_valid/entry/result/pc_out/pc_init, alu_full : ALU completion push
//   ld_valid/entry/result/pc_out, ld_full           : load completion push
//   st_valid/entry/addr/data/pc_out, st_full        : store completion push
//   cdb_valid/src/entry/result/addr/pc_out/pc_init  : registered broadcast
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int ENTRY_W = ROBENTRY_W,
  parameter int DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy,
  input  logic               rollback,
  input  logic               alu_valid,
  input  logic [ENTRY_W-1:0] alu_entry,
  input  logic [31:0]        alu_result,
  input  logic [31:0]        alu_pc_out,
  input  logic [31:0]        alu_pc_init,
  output logic               alu_full,
  input  logic               ld_valid,
  input  logic [ENTRY_W-1:0] ld_entry,
  input  logic [31:0]        ld_result,
  input  logic [31:0]        ld_pc_out,
  output logic               ld_full,
  input  logic               st_valid,
  input  logic [ENTRY_W-1:0] st_entry,
  input  logic [31:0]        st_addr,
  input  logic [31:0]        st_data,
  input  logic [31:0]        st_pc_out,
  output logic               st_full,
  output logic               cdb_valid,
  output logic [1:0]         cdb_src,
  output logic [ENTRY_W-1:0] cdb_entry,
  output logic [31:0]        cdb_result,
  output logic [31:0]        cdb_addr,
  output logic [31:0]        cdb_pc_out,
  output logic [31:0]        cdb_pc_init
);

  localparam int                 CNT_W    = $clog2(DEPTH + 1);
  localparam int                 ALU_W    = ENTRY_W + 96;
  localparam int                 LD_W     = ENTRY_W + 64;
  localparam int                 ST_W     = ENTRY_W + 96;
  localparam logic [ENTRY_W-1:0] NULL_TAG = ENTRY_W'(ENTRY_NULL);

  logic [ALU_W-1:0] alu_head;
  logic [LD_W-1:0]  ld_head;
  logic [ST_W-1:0]  st_head;
  logic [CNT_W-1:0] alu_cnt, ld_cnt, st_cnt;
  logic             alu_push, ld_push, st_push;
  logic             alu_pop, ld_pop, st_pop;
  cdb_grant_t       grant;

  cdb_src_e           rr_q, rr_d;
  logic               valid_q, valid_d;
  cdb_src_e           src_q, src_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [31:0]        result_q, result_d;
  logic [31:0]        addr_q, addr_d;
  logic [31:0]        pc_out_q, pc_out_d;
  logic [31:0]        pc_init_q, pc_init_d;

  // rdy low freezes everything, so pushes are gated here rather than in the FIFO.
  assign alu_push = rdy && alu_valid;
  assign ld_push  = rdy && ld_valid;
  assign st_push  = rdy && st_valid;

  cdb_src_fifo #(.WIDTH(ALU_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_alu_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(rollback),
    .push (alu_push),
    .pop  (alu_pop),
    .din  ({alu_entry, alu_result, alu_pc_out, alu_pc_init}),
    .head (alu_head),
    .count(alu_cnt),
    .full (alu_full)
  );

  cdb_src_fifo #(.WIDTH(LD_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_ld_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(rollback),
    .push (ld_push),
    .pop  (ld_pop),
    .din  ({ld_entry, ld_result, ld_pc_out}),
    .head (ld_head),
    .count(ld_cnt),
    .full (ld_full)
  );

  cdb_src_fifo #(.WIDTH(ST_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_st_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(rollback),
    .push (st_push),
    .pop  (st_pop),
    .din  ({st_entry, st_addr, st_data, st_pc_out}),
    .head (st_head),
    .count(st_cnt),
    .full (st_full)
  );

  // Candidates use pre-edge counts, so an item pushed at this edge waits one cycle.
  always_comb begin
    grant = cdb_rr_pick(rr_q, {1'b0, st_cnt != '0, ld_cnt != '0, alu_cnt != '0});
    alu_pop = rdy && grant.hit && (grant.id == CDB_SRC_ALU);
    ld_pop  = rdy && grant.hit && (grant.id == CDB_SRC_LOAD);
    st_pop  = rdy && grant.hit && (grant.id == CDB_SRC_STORE);
  end

  always_comb begin
    rr_d      = rr_q;
    valid_d   = valid_q;
    src_d     = src_q;
    entry_d   = entry_q;
    result_d  = result_q;
    addr_d    = addr_q;
    pc_out_d  = pc_out_q;
    pc_init_d = pc_init_q;
    if (rdy) begin
      if (grant.hit) begin
        valid_d = 1'b1;
        src_d   = grant.id;
        rr_d    = cdb_src_next(grant.id);
        case (grant.id)
          CDB_SRC_ALU: begin
            entry_d   = alu_head[ALU_W-1 -: ENTRY_W];
            result_d  = alu_head[95:64];
            addr_d    = '0;
            pc_out_d  = alu_head[63:32];
            pc_init_d = alu_head[31:0];
          end
          CDB_SRC_LOAD: begin
            entry_d   = ld_head[LD_W-1 -: ENTRY_W];
            result_d  = ld_head[63:32];
            addr_d    = '0;
            pc_out_d  = ld_head[31:0];
            pc_init_d = '0;
          end
          default: begin
            entry_d   = st_head[ST_W-1 -: ENTRY_W];
            addr_d    = st_head[95:64];
            result_d  = st_head[63:32];
            pc_out_d  = st_head[31:0];
            pc_init_d = '0;
          end
        endcase
      end else begin
        // Idle cycle: drop valid, keep the last payload on the bus.
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q      <= CDB_SRC_ALU;
      valid_q   <= 1'b0;
      src_q     <= CDB_SRC_ALU;
      entry_q   <= NULL_TAG;
      result_q  <= '0;
      addr_q    <= '0;
      pc_out_q  <= '0;
      pc_init_q <= '0;
    end else if (rollback) begin
      // Only valid/tag are cleared; stale payload is harmless without valid.
      rr_q    <= CDB_SRC_ALU;
      valid_q <= 1'b0;
      entry_q <= NULL_TAG;
    end else begin
      rr_q      <= rr_d;
      valid_q   <= valid_d;
      src_q     <= src_d;
      entry_q   <= entry_d;
      result_q  <= result_d;
      addr_q    <= addr_d;
      pc_out_q  <= pc_out_d;
      pc_init_q <= pc_init_d;
    end
  end

  assign cdb_valid   = valid_q;
  assign cdb_src     = src_q;
  assign cdb_entry   = entry_q;
  assign cdb_result  = result_q;
  assign cdb_addr    = addr_q;
  assign cdb_pc_out  = pc_out_q;
  assign cdb_pc_init = pc_init_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - self-checking bench for cdb_arbiter
module tb_cdb_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy, rollback;
  logic        alu_valid, ld_valid, st_valid;
  logic [5:0]  alu_entry, ld_entry, st_entry;
  logic [31:0] alu_result, alu_pc_out, alu_pc_init;
  logic [31:0] ld_result, ld_pc_out;
  logic [31:0] st_addr, st_data, st_pc_out;
  logic        alu_full, ld_full, st_full;
  logic        cdb_valid;
  logic [1:0]  cdb_src;
  logic [5:0]  cdb_entry;
  logic [31:0] cdb_result, cdb_addr, cdb_pc_out, cdb_pc_init;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cdb_arbiter #(.ENTRY_W(6), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
    .alu_valid(alu_valid), .alu_entry(alu_entry), .alu_result(alu_result),
    .alu_pc_out(alu_pc_out), .alu_pc_init(alu_pc_init), .alu_full(alu_full),
    .ld_valid(ld_valid), .ld_entry(ld_entry), .ld_result(ld_result),
    .ld_pc_out(ld_pc_out), .ld_full(ld_full),
    .st_valid(st_valid), .st_entry(st_entry), .st_addr(st_addr),
    .st_data(st_data), .st_pc_out(st_pc_out), .st_full(st_full),
    .cdb_valid(cdb_valid), .cdb_src(cdb_src), .cdb_entry(cdb_entry),
    .cdb_result(cdb_result), .cdb_addr(cdb_addr), .cdb_pc_out(cdb_pc_out),
    .cdb_pc_init(cdb_pc_init)
  );

  // Inputs applied before an edge, expected outputs sampled just after it.
  typedef struct packed {
    logic        rst, rdy, rb;
    logic        av; logic [5:0] ae; logic [31:0] ar; logic [31:0] api;
    logic        lv; logic [5:0] le;
    logic        sv; logic [5:0] se; logic [31:0] sa; logic [31:0] sd;
    logic        ev; logic [1:0] es; logic [5:0] ee;
    logic [31:0] er; logic [31:0] ea; logic [31:0] epi;
    logic [2:0]  efull;  // {st, ld, alu}
    logic        chk;    // compare payload even when ev=0
  } vec_t;

  vec_t vt[33];

  task automatic check(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step=%0d actual=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic drive_idle();
    rst = 1'b0; rdy = 1'b1; rollback = 1'b0;
    alu_valid = 1'b0; alu_entry = '0; alu_result = '0; alu_pc_out = '0; alu_pc_init = '0;
    ld_valid = 1'b0; ld_entry = '0; ld_result = '0; ld_pc_out = '0;
    st_valid = 1'b0; st_entry = '0; st_addr = '0; st_data = '0; st_pc_out = '0;
  endtask

  task automatic apply(input vec_t t);
    rst = t.rst; rdy = t.rdy; rollback = t.rb;
    alu_valid = t.av; alu_entry = t.ae; alu_result = t.ar;
    alu_pc_init = t.api; alu_pc_out = t.api + 32'd4;
    ld_valid = t.lv; ld_entry = t.le;
    ld_result = 32'h5000_0000 | {26'h0, t.le}; ld_pc_out = 32'h3000 + {26'h0, t.le};
    st_valid = t.sv; st_entry = t.se; st_addr = t.sa; st_data = t.sd;
    st_pc_out = 32'h3000 + {26'h0, t.se};
  endtask

  task automatic compare(input vec_t t, input int i);
    logic [31:0] epo;
    epo = !t.ev ? 32'h0 : (t.es == 2'd0) ? t.epi + 32'd4 : 32'h3000 + {26'h0, t.ee};
    check("cdb_valid", i, {31'h0, cdb_valid}, {31'h0, t.ev});
    check("cdb_entry", i, {26'h0, cdb_entry}, {26'h0, t.ee});
    check("full_flags", i, {29'h0, st_full, ld_full, alu_full}, {29'h0, t.efull});
    if (t.ev || t.chk) begin
      check("cdb_src", i, {30'h0, cdb_src}, {30'h0, t.es});
      check("cdb_result", i, cdb_result, t.er);
      check("cdb_addr", i, cdb_addr, t.ea);
      check("cdb_pc_init", i, cdb_pc_init, t.epi);
      check("cdb_pc_out", i, cdb_pc_out, epo);
    end
  endtask

  // Backpressure scoreboard
  logic [5:0] aq[$];
  logic [5:0] lq[$];
  int         prev_src;

  task automatic observe(input bit push_phase, input int e);
    logic [5:0] exp_tag;
    if (push_phase) check("bp_valid", e, {31'h0, cdb_valid}, {31'h0, e > 0});
    if (cdb_valid) begin
      if (cdb_src == 2'd0) begin
        exp_tag = (aq.size() > 0) ? aq.pop_front() : 6'h3E;
        check("bp_alu_tag", e, {26'h0, cdb_entry}, {26'h0, exp_tag});
      end else if (cdb_src == 2'd1) begin
        exp_tag = (lq.size() > 0) ? lq.pop_front() : 6'h3E;
        check("bp_ld_tag", e, {26'h0, cdb_entry}, {26'h0, exp_tag});
      end else begin
        check("bp_src", e, {30'h0, cdb_src}, 32'h0);
      end
      if (push_phase && prev_src >= 0)
        check("bp_alternate", e, {31'h0, cdb_src != 2'(prev_src)}, 32'h1);
      prev_src = int'(cdb_src);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_af, seen_lf;
    int a_tag, l_tag;

    //        rst rdy rb  av ae  ar         api       lv le  sv se   sa          sd        ev es    ee   er              ea          epi       full chk
    vt[0]  = '{1'b1,1'b0,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b1};
    vt[1]  = vt[0];
    vt[2]  = '{1'b0,1'b1,1'b0, 1'b1,6'd1, 32'h11,    32'h200,  1'b1,6'd2, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[3]  = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd0,6'd1, 32'h11,         32'h0,      32'h200,  3'b000,1'b0};
    vt[4]  = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd1,6'd2, 32'h5000_0002,  32'h0,      32'h0,    3'b000,1'b0};
    vt[5]  = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd2, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[6]  = '{1'b0,1'b1,1'b0, 1'b1,6'd5, 32'h1234,  32'h100,  1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd2, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[7]  = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd0,6'd5, 32'h1234,       32'h0,      32'h100,  3'b000,1'b0};
    vt[8]  = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd5, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[9]  = '{1'b0,1'b1,1'b1, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[10] = '{1'b0,1'b1,1'b0, 1'b1,6'd1, 32'h101,   32'h400,  1'b1,6'd2, 1'b1,6'd3, 32'h2000,  32'hAB,   1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[11] = '{1'b0,1'b1,1'b0, 1'b1,6'd4, 32'h104,   32'h410,  1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd0,6'd1, 32'h101,        32'h0,      32'h400,  3'b000,1'b0};
    vt[12] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd1,6'd2, 32'h5000_0002,  32'h0,      32'h0,    3'b000,1'b0};
    vt[13] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd2,6'd3, 32'hAB,         32'h2000,   32'h0,    3'b000,1'b0};
    vt[14] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd0,6'd4, 32'h104,        32'h0,      32'h410,  3'b000,1'b0};
    vt[15] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd4, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[16] = '{1'b0,1'b1,1'b0, 1'b1,6'd7, 32'h700,   32'h500,  1'b1,6'd9, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd4, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[17] = '{1'b0,1'b1,1'b1, 1'b1,6'd8, 32'h800,   32'h510,  1'b0,6'd0, 1'b1,6'd10,32'h2100,  32'hCD,   1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[18] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[19] = vt[18];
    vt[20] = '{1'b0,1'b1,1'b0, 1'b1,6'd11,32'hB00,   32'h600,  1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[21] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd0,6'd11,32'hB00,        32'h0,      32'h600,  3'b000,1'b0};
    vt[22] = '{1'b0,1'b1,1'b1, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[23] = vt[18];
    vt[24] = '{1'b0,1'b1,1'b0, 1'b1,6'd3, 32'h333,   32'h700,  1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd0, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[25] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,6'd6, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd0,6'd3, 32'h333,        32'h0,      32'h700,  3'b000,1'b0};
    vt[26] = '{1'b0,1'b0,1'b0, 1'b1,6'd12,32'hC00,   32'h710,  1'b1,6'd13,1'b1,6'd14,32'h2200,  32'hEE,   1'b1,2'd0,6'd3, 32'h333,        32'h0,      32'h700,  3'b000,1'b0};
    vt[27] = vt[26];
    vt[28] = vt[26];
    vt[29] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b1,2'd1,6'd6, 32'h5000_0006,  32'h0,      32'h0,    3'b000,1'b0};
    vt[30] = '{1'b0,1'b1,1'b0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,6'd0, 1'b0,6'd0, 32'h0,     32'h0,    1'b0,2'd0,6'd6, 32'h0,          32'h0,      32'h0,    3'b000,1'b0};
    vt[31] = vt[30];
    vt[32] = vt[0];

    drive_idle();
    rst = 1'b1;
    rdy = 1'b0;

    for (int i = 0; i < 33; i++) begin
      @(negedge clk);
      apply(vt[i]);
      @(posedge clk);
      #1;
      compare(vt[i], i);
    end

    // Backpressure: push ALU and LOAD every edge; ALU keeps pushing a
    // poison tag while full, which must never appear on the bus.
    seen_af  = 1'b0;
    seen_lf  = 1'b0;
    a_tag    = 16;
    l_tag    = 32;
    prev_src = -1;
    for (int e = 0; e < 8; e++) begin
      @(negedge clk);
      drive_idle();
      if (alu_full) seen_af = 1'b1;
      if (ld_full)  seen_lf = 1'b1;
      alu_valid = 1'b1;
      if (!alu_full) begin
        alu_entry = 6'(a_tag);
        aq.push_back(6'(a_tag));
        a_tag++;
      end else begin
        alu_entry = 6'h3F;
      end
      if (!ld_full) begin
        ld_valid = 1'b1;
        ld_entry = 6'(l_tag);
        lq.push_back(6'(l_tag));
        l_tag++;
      end
      @(posedge clk);
      #1;
      observe(1'b1, e);
    end
    for (int e = 8; e < 16; e++) begin
      @(negedge clk);
      drive_idle();
      @(posedge clk);
      #1;
      observe(1'b0, e);
    end
    check("bp_alu_full_seen", 0, {31'h0, seen_af}, 32'h1);
    check("bp_ld_full_seen", 0, {31'h0, seen_lf}, 32'h1);
    check("bp_alu_drained", 0, aq.size(), 32'h0);
    check("bp_ld_drained", 0, lq.size(), 32'h0);
    check("bp_idle_valid", 0, {31'h0, cdb_valid}, 32'h0);
    check("bp_idle_full", 0, {29'h0, st_full, ld_full, alu_full}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
